// File: rtl/hazard_ctrl_pipe.sv
// hazard_ctrl_pipe: hazard controller for a 5-stage (F/D/E/M/W) RISC-V pipeline.
//
// Purpose:
//   Selects E-stage operand forwarding, inserts load-use bubbles, flushes on
//   taken branches/jumps, freezes the pipeline while data memory is busy, defers
//   a redirect flush that resolves during a freeze, and flags over-long memory waits.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rs1_d, rs2_d                  D-stage source registers
//   rs1_e, rs2_e, rd_e            E-stage sources and destination
//   rd_m, rd_w                    M/W-stage destinations
//   mem_read_e                    E-stage instruction is a load
//   reg_write_m, reg_write_w      M/W-stage instruction writes the register file
//   redirect_e                    taken branch/jump resolved in E
//   mem_req_m, mem_ready          M-stage memory access active / completed
//   fwd_a_e, fwd_b_e              operand select: 00 RF, 01 W result, 10 M result
//   stall_f, stall_d              hold PC and F/D register
//   flush_d, flush_e              clear F/D and D/E registers
//   freeze_m                      hold E/M and M/W registers (bubble into W)
//   mem_timeout                   sticky: a memory wait reached MEM_TIMEOUT cycles
//   state_o                       FSM state (00 RUN, 01 LU_STALL, 10 MEM_WAIT)
//
// Optional build macro HAZARD_PERF_CNT_EN adds 32-bit wrapping counters
// perf_stall_cnt, perf_flush_cnt (redirect flushes) and perf_wait_cnt.

module hazard_ctrl_pipe #(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned LU_STALL_CYC = 1,
    parameter int unsigned MEM_TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  mem_read_e,
    input  logic                  reg_write_m,
    input  logic                  reg_write_w,
    input  logic                  redirect_e,
    input  logic                  mem_req_m,
    input  logic                  mem_ready,
    output logic [1:0]            fwd_a_e,
    output logic [1:0]            fwd_b_e,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  freeze_m,
    output logic                  mem_timeout,
    output logic [1:0]            state_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt,
    output logic [31:0]           perf_wait_cnt
`endif
);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StLuStall = 2'b01,
        StMemWait = 2'b10,
        StUnused  = 2'b11
    } state_e;

    localparam logic [15:0] WaitMax = 16'(MEM_TIMEOUT);
    localparam logic [2:0]  LuInit  = 3'(LU_STALL_CYC - 1);

    state_e      state_q, state_d;
    logic [2:0]  lu_cnt_q, lu_cnt_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        pend_flush_q, pend_flush_d;
    logic        timeout_q, timeout_d;

    logic memwait, lu_haz;
    logic stall_req, flush_fd_req, flush_de_req, freeze_req;

    // M result has priority over W result; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                           input logic                  wr_m,
                                           input logic [REG_ADDR_W-1:0] dst_m,
                                           input logic                  wr_w,
                                           input logic [REG_ADDR_W-1:0] dst_w);
        if (wr_m && (dst_m != '0) && (dst_m == rs)) begin
            return 2'b10;
        end else if (wr_w && (dst_w != '0) && (dst_w == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign fwd_a_e = fwd_sel(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w);
    assign fwd_b_e = fwd_sel(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w);

    assign memwait = mem_req_m && !mem_ready;
    assign lu_haz  = mem_read_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    always_comb begin
        state_d      = state_q;
        lu_cnt_d     = lu_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        pend_flush_d = pend_flush_q;
        timeout_d    = timeout_q;
        stall_req    = 1'b0;
        flush_fd_req = 1'b0;
        flush_de_req = 1'b0;
        freeze_req   = 1'b0;

        unique case (state_q)
            StRun, StLuStall: begin
                if (memwait) begin
                    // Memory wait wins; pending load-use bubbles are re-detected afterwards.
                    stall_req    = 1'b1;
                    freeze_req   = 1'b1;
                    state_d      = StMemWait;
                    pend_flush_d = redirect_e;
                    wait_cnt_d   = 16'd1;
                    lu_cnt_d     = '0;
                end else if (state_q == StLuStall) begin
                    stall_req    = 1'b1;
                    flush_de_req = 1'b1;
                    lu_cnt_d     = lu_cnt_q - 3'd1;
                    if (lu_cnt_q <= 3'd1) begin
                        state_d = StRun;
                    end
                end else if (redirect_e) begin
                    // Younger instruction is flushed, so any load-use hazard is moot.
                    flush_fd_req = 1'b1;
                    flush_de_req = 1'b1;
                end else if (lu_haz) begin
                    stall_req    = 1'b1;
                    flush_de_req = 1'b1;
                    if (LU_STALL_CYC > 1) begin
                        state_d  = StLuStall;
                        lu_cnt_d = LuInit;
                    end
                end
            end
            StMemWait: begin
                if (memwait) begin
                    stall_req    = 1'b1;
                    freeze_req   = 1'b1;
                    pend_flush_d = pend_flush_q || redirect_e;
                    if (wait_cnt_q != WaitMax) begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end
                end else begin
                    // Release cycle: apply the redirect deferred during the freeze.
                    flush_fd_req = pend_flush_q || redirect_e;
                    flush_de_req = pend_flush_q || redirect_e;
                    pend_flush_d = 1'b0;
                    wait_cnt_d   = '0;
                    state_d      = StRun;
                end
            end
            default: state_d = StRun;
        endcase

        // wait_cnt_d counts wait cycles including this one.
        if (memwait && (wait_cnt_d == WaitMax)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StRun;
            lu_cnt_q     <= '0;
            wait_cnt_q   <= '0;
            pend_flush_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lu_cnt_q     <= lu_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            pend_flush_q <= pend_flush_d;
            timeout_q    <= timeout_d;
        end
    end

    assign stall_f     = !rst && stall_req;
    assign stall_d     = !rst && stall_req;
    assign flush_d     = !rst && flush_fd_req;
    assign flush_e     = !rst && flush_de_req;
    assign freeze_m    = !rst && freeze_req;
    assign mem_timeout = timeout_q;
    assign state_o     = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_flush_q, perf_wait_q;

    // flush_d is only ever raised by a redirect, so it marks redirect flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_wait_q  <= '0;
        end else begin
            perf_stall_q <= perf_stall_q + {31'd0, stall_req};
            perf_flush_q <= perf_flush_q + {31'd0, flush_fd_req};
            perf_wait_q  <= perf_wait_q + {31'd0, (state_q == StMemWait)};
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
    assign perf_wait_cnt  = perf_wait_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Self-checking bench for hazard_ctrl_pipe: directed scenarios followed by
// randomized traffic, all checked against a cycle-level behavioural model.

module tb_hazard_ctrl_pipe;

    localparam int unsigned AW = 5;
    localparam int unsigned LU = 3;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic          mem_read_e, reg_write_m, reg_write_w, redirect_e, mem_req_m, mem_ready;
    logic [1:0]    fwd_a_e, fwd_b_e, state_o;
    logic          stall_f, stall_d, flush_d, flush_e, freeze_m, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]   perf_stall_cnt, perf_flush_cnt, perf_wait_cnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl_pipe #(
        .REG_ADDR_W  (AW),
        .LU_STALL_CYC(LU),
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rs1_d      (rs1_d),
        .rs2_d      (rs2_d),
        .rs1_e      (rs1_e),
        .rs2_e      (rs2_e),
        .rd_e       (rd_e),
        .rd_m       (rd_m),
        .rd_w       (rd_w),
        .mem_read_e (mem_read_e),
        .reg_write_m(reg_write_m),
        .reg_write_w(reg_write_w),
        .redirect_e (redirect_e),
        .mem_req_m  (mem_req_m),
        .mem_ready  (mem_ready),
        .fwd_a_e    (fwd_a_e),
        .fwd_b_e    (fwd_b_e),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .flush_d    (flush_d),
        .flush_e    (flush_e),
        .freeze_m   (freeze_m),
        .mem_timeout(mem_timeout),
        .state_o    (state_o)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt),
        .perf_wait_cnt (perf_wait_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model state: remaining load-use bubbles, in-wait flag, consecutive wait
    // cycles seen, deferred redirect, sticky timeout, and event counters.
    int          m_bub  = 0;
    bit          m_wait = 1'b0;
    int          m_wn   = 0;
    bit          m_pend = 1'b0;
    bit          m_to   = 1'b0;
    int unsigned p_stall = 0, p_flush = 0, p_wait = 0;

    function automatic logic [1:0] fwd_ref(input logic [AW-1:0] rs);
        if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Inputs are applied just after a clock edge; check mid-cycle, advance the
    // model, and return just after the next edge.
    task automatic step();
        bit mw, haz, e_stall, e_fd, e_fe, e_frz;
        logic [1:0] e_state;
        #1;
        mw  = mem_req_m && !mem_ready;
        haz = mem_read_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
        e_stall = 0; e_fd = 0; e_fe = 0; e_frz = 0;
        e_state = m_wait ? 2'b10 : (m_bub > 0 ? 2'b01 : 2'b00);

        check_val("fwd_a_e", {30'd0, fwd_a_e}, {30'd0, fwd_ref(rs1_e)});
        check_val("fwd_b_e", {30'd0, fwd_b_e}, {30'd0, fwd_ref(rs2_e)});
        check_val("state_o", {30'd0, state_o}, {30'd0, e_state});
        check_val("mem_timeout", {31'd0, mem_timeout}, {31'd0, m_to});
`ifdef HAZARD_PERF_CNT_EN
        check_val("perf_stall", perf_stall_cnt, p_stall);
        check_val("perf_flush", perf_flush_cnt, p_flush);
        check_val("perf_wait", perf_wait_cnt, p_wait);
`endif

        if (rst) begin
            m_bub = 0; m_wait = 0; m_wn = 0; m_pend = 0; m_to = 0;
            p_stall = 0; p_flush = 0; p_wait = 0;
        end else begin
            if (m_wait) p_wait++;
            if (m_wait) begin
                if (mw) begin
                    e_stall = 1; e_frz = 1;
                    m_pend = m_pend || redirect_e;
                    m_wn++;
                end else begin
                    e_fd = m_pend || redirect_e; e_fe = e_fd;
                    m_wait = 0; m_wn = 0; m_pend = 0;
                end
            end else if (mw) begin
                e_stall = 1; e_frz = 1;
                m_wait = 1; m_wn = 1; m_pend = redirect_e; m_bub = 0;
            end else if (m_bub > 0) begin
                e_stall = 1; e_fe = 1;
                m_bub--;
            end else if (redirect_e) begin
                e_fd = 1; e_fe = 1;
            end else if (haz) begin
                e_stall = 1; e_fe = 1;
                m_bub = LU - 1;
            end
            if (mw && m_wn >= TO) m_to = 1;
            if (e_stall) p_stall++;
            if (e_fd) p_flush++;
        end

        check_val("stall_f", {31'd0, stall_f}, {31'd0, e_stall});
        check_val("stall_d", {31'd0, stall_d}, {31'd0, e_stall});
        check_val("flush_d", {31'd0, flush_d}, {31'd0, e_fd});
        check_val("flush_e", {31'd0, flush_e}, {31'd0, e_fe});
        check_val("freeze_m", {31'd0, freeze_m}, {31'd0, e_frz});
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rst = 0; rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        mem_read_e = 0; reg_write_m = 0; reg_write_w = 0; redirect_e = 0;
        mem_req_m = 0; mem_ready = 0;
    endtask

    initial begin
        clr();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        step();
        rst = 0;

        // Forwarding priority and x0.
        reg_write_m = 1; rd_m = 5; rs1_e = 5; reg_write_w = 1; rd_w = 5; rs2_e = 5;
        #1;
        check_val("fwd_a_m_prio", {30'd0, fwd_a_e}, 32'd2);
        check_val("fwd_b_m_prio", {30'd0, fwd_b_e}, 32'd2);
        step();
        rd_m = 0; rs1_e = 0;
        #1;
        check_val("fwd_a_x0", {30'd0, fwd_a_e}, 32'd0);
        check_val("fwd_b_w", {30'd0, fwd_b_e}, 32'd1);
        step();

        // Load-use: three bubbles.
        clr();
        mem_read_e = 1; rd_e = 7; rs2_d = 7;
        step();
        mem_read_e = 0;
        repeat (3) step();

        // Memory wait of 4 cycles, with a redirect deferred to the release cycle.
        mem_req_m = 1; mem_ready = 0;
        step();
        redirect_e = 1;
        step();
        redirect_e = 0;
        repeat (2) step();
        mem_ready = 1;
        step();
        mem_req_m = 0;
        step();

        // Timeout: 10 wait cycles, flag persists after release.
        mem_req_m = 1; mem_ready = 0;
        repeat (10) step();
        mem_ready = 1;
        step();
        mem_req_m = 0;
        repeat (2) step();
        check_val("timeout_sticky", {31'd0, mem_timeout}, 32'd1);

        // Reset in the middle of a wait.
        mem_req_m = 1; mem_ready = 0;
        repeat (3) step();
        rst = 1;
        step();
        rst = 0; mem_req_m = 0;
        check_val("rst_state", {30'd0, state_o}, 32'd0);
        check_val("rst_timeout", {31'd0, mem_timeout}, 32'd0);
        step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 99) == 0);
            rs1_d       = AW'($urandom_range(0, 3));
            rs2_d       = AW'($urandom_range(0, 3));
            rs1_e       = AW'($urandom_range(0, 3));
            rs2_e       = AW'($urandom_range(0, 3));
            rd_e        = AW'($urandom_range(0, 3));
            rd_m        = AW'($urandom_range(0, 3));
            rd_w        = AW'($urandom_range(0, 3));
            mem_read_e  = ($urandom_range(0, 2) == 0);
            reg_write_m = 1'($urandom_range(0, 1));
            reg_write_w = 1'($urandom_range(0, 1));
            redirect_e  = (m_bub == 0) && ($urandom_range(0, 7) == 0);
            if (m_wait) begin
                mem_req_m = 1;
                mem_ready = ($urandom_range(0, 4) == 0);
            end else begin
                mem_req_m = ($urandom_range(0, 5) == 0);
                mem_ready = 1'($urandom_range(0, 1));
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
